// File: rtl/alu_exec_seq_if.sv
// rtl/alu_exec_seq_if.sv - request/ALU/response signal bundle for alu_exec_seq
// Purpose: groups the request handshake, ALU operand/result bus and response
//          handshake of alu_exec_seq into one interface.
// Modports:
//    slave  - the execution sequencer (accepts requests, drives ALU operands,
//             produces responses)
//    master - the environment (issues requests, provides the ALU result,
//             consumes responses)
interface alu_exec_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] imm;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_branch_taken;
   logic        rsp_illegal;

   modport slave (
      input  req_valid, opcode, funct3, funct7b5, rs1_data, rs2_data, imm,
             alu_result, alu_zero, rsp_ready,
      output req_ready, alu_a, alu_b, alu_ctrl,
             rsp_valid, rsp_result, rsp_branch_taken, rsp_illegal
   );

   modport master (
      output req_valid, opcode, funct3, funct7b5, rs1_data, rs2_data, imm,
             alu_result, alu_zero, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_ctrl,
             rsp_valid, rsp_result, rsp_branch_taken, rsp_illegal
   );
endinterface

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - single-issue decode/execute/respond sequencer for an external ALU
// Purpose: accepts one instruction request at a time, decodes it into ALU
//          operands and control, lets the external ALU evaluate for one EXEC
//          cycle, then presents the registered result until consumed.
// Ports:
//    clk    - sole clock, rising edge
//    reset  - synchronous, active-high
//    bus    - alu_exec_seq_if.slave (request, ALU operand/result, response)
// Configuration:
//    ALU_EXEC_SEQ_BNE_EN - when defined, branch funct3=001 (BNE) is legal.
// All outputs come straight from registers or the state register.
module alu_exec_seq (
   input  logic          clk,
   input  logic          reset,
   alu_exec_seq_if.slave bus
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic [3:0]  r_alu_ctrl;
   logic        r_is_branch;
   logic        r_is_bne;
   logic [31:0] r_rsp_result;
   logic        r_rsp_taken;
   logic        r_rsp_illegal;

   logic        w_legal;
   logic [3:0]  w_ctrl;
   logic        w_use_imm;
   logic        w_is_branch;
   logic        w_is_bne;

   // Instruction decode of the presented request fields.
   always_comb begin
      w_legal     = 1'b0;
      w_ctrl      = ALU_ADD;
      w_use_imm   = 1'b0;
      w_is_branch = 1'b0;
      w_is_bne    = 1'b0;
      case (bus.opcode)
         7'b0110011: begin
            case (bus.funct3)
               3'b000: begin
                  w_legal = 1'b1;
                  w_ctrl  = bus.funct7b5 ? ALU_SUB : ALU_ADD;
               end
               3'b111: begin w_legal = 1'b1; w_ctrl = ALU_AND; end
               3'b110: begin w_legal = 1'b1; w_ctrl = ALU_OR;  end
               default: ;
            endcase
         end
         7'b0010011: begin
            w_use_imm = 1'b1;
            case (bus.funct3)
               3'b000: begin w_legal = 1'b1; w_ctrl = ALU_ADD; end
               3'b111: begin w_legal = 1'b1; w_ctrl = ALU_AND; end
               3'b110: begin w_legal = 1'b1; w_ctrl = ALU_OR;  end
               default: ;
            endcase
         end
         7'b0000011, 7'b0100011: begin
            w_legal   = 1'b1;
            w_ctrl    = ALU_ADD;
            w_use_imm = 1'b1;
         end
         7'b1100011: begin
            w_ctrl      = ALU_SUB;
            w_is_branch = 1'b1;
            case (bus.funct3)
               3'b000: w_legal = 1'b1;
`ifdef ALU_EXEC_SEQ_BNE_EN
               3'b001: begin w_legal = 1'b1; w_is_bne = 1'b1; end
`endif
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Illegal requests skip EXEC: their response is known at capture time.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.req_valid) w_state_nxt = w_legal ? EXEC : RESP;
         EXEC:    w_state_nxt = RESP;
         RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operands are only written in IDLE, so they stay stable through EXEC and
   // are left untouched by illegal requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_ctrl    <= ALU_AND;
         r_is_branch   <= 1'b0;
         r_is_bne      <= 1'b0;
         r_rsp_result  <= '0;
         r_rsp_taken   <= 1'b0;
         r_rsp_illegal <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  if (w_legal) begin
                     r_alu_a     <= bus.rs1_data;
                     r_alu_b     <= w_use_imm ? bus.imm : bus.rs2_data;
                     r_alu_ctrl  <= w_ctrl;
                     r_is_branch <= w_is_branch;
                     r_is_bne    <= w_is_bne;
                  end else begin
                     r_rsp_result  <= '0;
                     r_rsp_taken   <= 1'b0;
                     r_rsp_illegal <= 1'b1;
                  end
               end
            end
            EXEC: begin
               r_rsp_result  <= bus.alu_result;
               // BEQ takes on equal (zero), BNE on not-equal.
               r_rsp_taken   <= r_is_branch & (r_is_bne ? ~bus.alu_zero : bus.alu_zero);
               r_rsp_illegal <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready        = (r_state == IDLE);
   assign bus.rsp_valid        = (r_state == RESP);
   assign bus.alu_a            = r_alu_a;
   assign bus.alu_b            = r_alu_b;
   assign bus.alu_ctrl         = r_alu_ctrl;
   assign bus.rsp_result       = r_rsp_result;
   assign bus.rsp_branch_taken = r_rsp_taken;
   assign bus.rsp_illegal      = r_rsp_illegal;

endmodule

// File: doc/alu_exec_seq.md
ALU_EXEC_SEQ -- requirements
Module: alu_exec_seq

Interface
REQ-001 The block SHALL provide these ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  instruction request valid
- req_ready  out  1  block can accept a request
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- rs1_data, rs2_data, imm  in  32 each  operand sources
- alu_a, alu_b  out  32 each  operands to the ALU
- alu_ctrl  out  4  ALU control code
- alu_result  in  32  combinational ALU result
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured ALU result
- rsp_branch_taken  out  1  branch condition met
- rsp_illegal  out  1  unsupported encoding
REQ-002 One clock; reset is synchronous and active-high; ports named clk and reset.
REQ-003 All outputs SHALL be driven from registers or the state register; there is no combinational path from any input to any output.

Function
REQ-004 FSM states: IDLE, EXEC, RESP; req_ready=1 only in IDLE, rsp_valid=1 only in RESP.
REQ-005 IDLE: on req_valid=1, capture all request fields and decode; legal goes to EXEC, illegal goes to RESP.
REQ-006 Decoding SHALL map alu_ctrl as follows:
- ADD=0010, SUB=0110, AND=0000, OR=0001.
- opcode 0110011 (R): funct3 000 gives ADD if funct7b5=0, else SUB; 111 gives AND; 110 gives OR; others illegal; B=rs2.
- opcode 0010011 (I): 000 ADD, 111 AND, 110 OR, others illegal; B=imm.
- opcode 0000011 / 0100011 (load/store): ADD, B=imm.
- opcode 1100011 (branch): SUB, B=rs2; funct3 000 (BEQ) legal, 001 per REQ-016, others illegal.
- Any other opcode is illegal.
REQ-007 alu_a=rs1_data for all legal ops.
REQ-008 alu_a, alu_b and alu_ctrl SHALL be held stable throughout EXEC.
REQ-009 EXEC lasts exactly one cycle. At its end, register rsp_result=alu_result and compute rsp_branch_taken; go to RESP.
REQ-010 rsp_branch_taken=1 only for a legal branch whose condition holds (BEQ: alu_zero=1); 0 for all non-branch ops.
REQ-011 Illegal requests: no EXEC cycle; rsp_illegal=1, rsp_result=0, rsp_branch_taken=0; alu_* retain their previous values.
REQ-012 RESP: hold all rsp_* stable while rsp_ready=0; when rsp_ready=1, go to IDLE on the next edge.
- A new request is not accepted in the same cycle.
REQ-013 Latency and throughput:
- Legal op accepted at edge N: rsp_valid from edge N+2.
- Illegal op: rsp_valid from edge N+1.
- Maximum throughput is one request per 3 cycles.
REQ-014 Requests presented while req_ready=0 SHALL be ignored and not captured.

Reset
REQ-015 Reset SHALL take effect on a clk edge with reset=1, from any state, and discard any in-flight transaction:
- state=IDLE
- rsp_valid=0, rsp_result=0, rsp_branch_taken=0, rsp_illegal=0
- alu_a=0, alu_b=0, alu_ctrl=0000
- req_ready=1 on the cycle after reset deasserts.

Configuration
REQ-016 Macro ALU_EXEC_SEQ_BNE_EN controls BNE support:
- Defined: branch funct3 001 (BNE) is legal; SUB is issued; taken when alu_zero=0.
- Undefined: funct3 001 is illegal per REQ-011.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- R-type SUB: rs1=10, rs2=3, funct7b5=1 -> alu_ctrl=0110; rsp_result=7 at N+2; taken=0; illegal=0.
- BEQ: rs1=rs2=0x55 -> alu_ctrl=0110; rsp_result=0; taken=1.
- BNE: rs1=1, rs2=2 -> with macro, taken=1; without macro, illegal=1 at N+1 and result=0.
- Backpressure: ORI rs1=0xF0, imm=0x0F with rsp_ready=0 for 5 cycles -> rsp_result=0xFF held stable; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Reset during EXEC (load, rs1=0x100, imm=4) -> next cycle: state IDLE, rsp_valid=0, alu_ctrl=0000; the following request completes normally.
- Opcode 1110011 -> rsp_illegal=1 at N+1; alu_* unchanged.
